win_col_feeder: RTL

// Producer side of the sliding-window column interface. Scans a feature map held in

---
 rtl/win_col_feeder_pkg.sv | 15 +
 rtl/win_col_feeder_if.sv | 26 ++
 rtl/win_col_feeder_addr_gen.sv | 91 +++++++++
 rtl/win_col_feeder.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/win_col_feeder_pkg.sv
// Shared types for the sliding-window column feeder: pixel width and FSM state encoding.
package npu_win_pkg;

    localparam int PIX_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_FETCH = 3'd2,
        ST_CAPT  = 3'd3,
        ST_PUSH  = 3'd4,
        ST_DONE  = 3'd5
    } feeder_state_e;

endpackage

// File: rtl/win_col_feeder_if.sv
// SRAM read port and column handshake between the feeder and the window register.
interface win_col_feeder_if #(
    parameter int K_H    = 3,
    parameter int ADDR_W = 6
);
    import npu_win_pkg::*;

    logic                        mem_rd_en;
    logic [ADDR_W-1:0]           mem_addr;
    logic [PIX_W-1:0]            mem_rdata;
    logic                        col_valid;
    logic                        col_ready;
    logic [K_H-1:0][PIX_W-1:0]   col_data;
    logic                        load_en;

    modport master (
        output mem_rd_en, mem_addr, col_valid, col_data, load_en,
        input  mem_rdata, col_ready
    );

    modport slave (
        input  mem_rd_en, mem_addr, col_valid, col_data, load_en,
        output mem_rdata, col_ready
    );

endinterface

// File: rtl/win_col_feeder_addr_gen.sv
// Row/column/pixel-index counters and SRAM address generation for the column feeder.
module win_addr_gen
    import npu_win_pkg::*;
#(
    parameter int K_H    = 3,
    parameter int IMG_H  = 8,
    parameter int IMG_W  = 8,
    parameter int ADDR_W = $clog2(IMG_H * IMG_W),
    parameter int ROW_W  = $clog2(IMG_H),
    parameter int COL_W  = $clog2(IMG_W),
    parameter int IDX_W  = (K_H > 1) ? $clog2(K_H) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              scan_init,
    input  logic              col_init,
    input  logic              fetch_step,
    input  logic              col_adv,
    input  logic              row_adv,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ROW_W-1:0]  row,
    output logic [COL_W-1:0]  col,
    output logic [IDX_W-1:0]  idx,
    output logic              idx_last,
    output logic              col_last,
    output logic              row_last
);

    // Walking down a column adds IMG_W; after the last pixel jump back up and one to the right.
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] REWIND   = ADDR_W'((K_H - 1) * IMG_W - 1);

    logic [ROW_W-1:0]  row_r;
    logic [ADDR_W-1:0] row_base_r;
    logic [COL_W-1:0]  col_r;
    logic [IDX_W-1:0]  idx_r;
    logic [ADDR_W-1:0] addr_r;

    // Output row counter and its base address accumulator
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_r      <= ROW_W'(0);
            row_base_r <= ADDR_W'(0);
        end else if (scan_init) begin
            row_r      <= ROW_W'(0);
            row_base_r <= ADDR_W'(0);
        end else if (row_adv) begin
            row_r      <= row_r + ROW_W'(1);
            row_base_r <= row_base_r + ROW_STEP;
        end
    end

    // Column counter, restarted at each row clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_r <= COL_W'(0);
        end else if (col_init) begin
            col_r <= COL_W'(0);
        end else if (col_adv) begin
            col_r <= col_r + COL_W'(1);
        end
    end

    // Pixel index and read address pointer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_r  <= IDX_W'(0);
            addr_r <= ADDR_W'(0);
        end else if (col_init) begin
            idx_r  <= IDX_W'(0);
            addr_r <= row_base_r;
        end else if (fetch_step) begin
            if (idx_last) begin
                idx_r  <= IDX_W'(0);
                addr_r <= addr_r - REWIND;
            end else begin
                idx_r  <= idx_r + IDX_W'(1);
                addr_r <= addr_r + ROW_STEP;
            end
        end
    end

    assign idx_last = (idx_r == IDX_W'(K_H - 1));
    assign col_last = (col_r == COL_W'(IMG_W - 1));
    assign row_last = (row_r == ROW_W'(IMG_H - K_H));
    assign mem_addr = addr_r;
    assign row      = row_r;
    assign col      = col_r;
    assign idx      = idx_r;

endmodule

// File: rtl/win_col_feeder.sv
// Scans a row-major feature map in SRAM and pushes K_H-pixel columns into the window register.
module win_col_feeder
    import npu_win_pkg::*;
#(
    parameter int K_H    = 3,
    parameter int K_W    = 3,
    parameter int IMG_H  = 8,
    parameter int IMG_W  = 8,
    parameter int ADDR_W = $clog2(IMG_H * IMG_W)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
    win_col_feeder_if.master          bus,
    output logic                      clear,
    output logic                      win_valid,
    output logic [$clog2(IMG_H)-1:0]  win_row,
    output logic [$clog2(IMG_W)-1:0]  win_col,
    output logic                      busy,
    output logic                      done
);

    localparam int ROW_W = $clog2(IMG_H);
    localparam int COL_W = $clog2(IMG_W);
    localparam int IDX_W = (K_H > 1) ? $clog2(K_H) : 1;

    feeder_state_e             state_r, next_s, base_next_s;
    logic [ROW_W-1:0]          row_s;
    logic [COL_W-1:0]          col_s;
    logic [IDX_W-1:0]          idx_s;
    logic                      idx_last_s, col_last_s, row_last_s;
    logic                      rd_en_s, col_valid_s, clear_s, busy_s, done_s, hs_s;
    logic                      scan_init_s, col_adv_s, row_adv_s;
    logic                      cap_en_r;
    logic [IDX_W-1:0]          cap_idx_r;
    logic [K_H-1:0][PIX_W-1:0] col_data_r;
    logic                      win_valid_r;
    logic [ROW_W-1:0]          win_row_r;
    logic [COL_W-1:0]          win_col_r;

    win_addr_gen #(
        .K_H(K_H), .IMG_H(IMG_H), .IMG_W(IMG_W), .ADDR_W(ADDR_W),
        .ROW_W(ROW_W), .COL_W(COL_W), .IDX_W(IDX_W)
    ) u_addr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .scan_init  (scan_init_s),
        .col_init   (state_r == ST_CLR),
        .fetch_step (rd_en_s),
        .col_adv    (col_adv_s),
        .row_adv    (row_adv_s),
        .mem_addr   (bus.mem_addr),
        .row        (row_s),
        .col        (col_s),
        .idx        (idx_s),
        .idx_last   (idx_last_s),
        .col_last   (col_last_s),
        .row_last   (row_last_s)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // FSM next-state logic; abort overrides every transition
    always_comb begin
        base_next_s = ST_IDLE;
        case (state_r)
            ST_IDLE:  base_next_s = start ? ST_CLR : ST_IDLE;
            ST_CLR:   base_next_s = ST_FETCH;
            ST_FETCH: base_next_s = idx_last_s ? ST_CAPT : ST_FETCH;
            ST_CAPT:  base_next_s = ST_PUSH;
            ST_PUSH: begin
                if (!bus.col_ready) begin
                    base_next_s = ST_PUSH;
                end else if (!col_last_s) begin
                    base_next_s = ST_FETCH;
                end else if (!row_last_s) begin
                    base_next_s = ST_CLR;
                end else begin
                    base_next_s = ST_DONE;
                end
            end
            ST_DONE:  base_next_s = ST_IDLE;
            default:  base_next_s = ST_IDLE;
        endcase
        if (abort) begin
            next_s = ST_IDLE;
        end else begin
            next_s = base_next_s;
        end
    end

    // FSM outputs decoded from the current state
    always_comb begin
        rd_en_s     = 1'b0;
        col_valid_s = 1'b0;
        done_s      = 1'b0;
        busy_s      = (state_r != ST_IDLE);
        case (state_r)
            ST_FETCH: rd_en_s     = !abort;
            ST_PUSH:  col_valid_s = !abort;
            ST_DONE:  done_s      = !abort;
            default:  rd_en_s     = 1'b0;
        endcase
        clear_s = (state_r == ST_CLR) || (abort && busy_s);
    end

    assign hs_s        = col_valid_s && bus.col_ready;
    assign scan_init_s = (state_r == ST_IDLE) && start && !abort;
    assign col_adv_s   = hs_s && !col_last_s;
    assign row_adv_s   = hs_s && col_last_s && !row_last_s;

    // SRAM data arrives one cycle after the strobe, so the index is delayed alongside it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cap_en_r   <= 1'b0;
            cap_idx_r  <= IDX_W'(0);
            col_data_r <= '0;
        end else begin
            cap_en_r  <= rd_en_s;
            cap_idx_r <= idx_s;
            if (cap_en_r) begin
                col_data_r[cap_idx_r] <= bus.mem_rdata;
            end
        end
    end

    // Window-full pulse with the position of the window it reports
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_valid_r <= 1'b0;
            win_row_r   <= ROW_W'(0);
            win_col_r   <= COL_W'(0);
        end else if (hs_s && (col_s >= COL_W'(K_W - 1))) begin
            win_valid_r <= 1'b1;
            win_row_r   <= row_s;
            win_col_r   <= col_s - COL_W'(K_W - 1);
        end else begin
            win_valid_r <= 1'b0;
        end
    end

    assign bus.mem_rd_en = rd_en_s;
    assign bus.col_valid = col_valid_s;
    assign bus.col_data  = col_data_r;
    assign bus.load_en   = hs_s;
    assign clear         = clear_s;
    assign busy          = busy_s;
    assign done          = done_s;
    assign win_valid     = win_valid_r;
    assign win_row       = win_row_r;
    assign win_col       = win_col_r;

endmodule
